// File: rtl/pc_control.sv
// rtl/pc_control.sv - program counter, fetch handshake and instruction sequencing
module pc_control #(
   parameter logic [63:0] RESET_PC = 64'h0
) (
   input  logic        clk,
   input  logic        reset_n,
   output logic        imem_req,
   output logic [63:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic        instr_valid,
   input  logic        stall,
   input  logic        branch,
   input  logic        jump,
   input  logic        alu_zero,
   input  logic [63:0] imm,
   output logic [63:0] pc,
   output logic [63:0] pc_plus4,
   output logic        taken,
   output logic        trap,
   output logic [63:0] instret
);

   typedef enum logic [1:0] {BOOT, FETCH, EXEC, TRAP} state_t;

   state_t      state, state_nxt;
   logic [63:0] pc_nxt;
   logic [63:0] instret_nxt;
   logic [31:0] instr_nxt;
   logic        trap_nxt;
   logic [63:0] target;
   logic        in_exec;

   assign in_exec     = (state == EXEC);
   assign taken       = in_exec & (jump | (branch & alu_zero));
   assign pc_plus4    = pc + 64'd4;
   assign target      = taken ? (pc + imm) : pc_plus4;
   assign imem_req    = (state == FETCH);
   assign imem_addr   = pc;
   assign instr_valid = in_exec;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= BOOT;
         pc      <= RESET_PC;
         instr   <= 32'h0;
         trap    <= 1'b0;
         instret <= 64'h0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         instr   <= instr_nxt;
         trap    <= trap_nxt;
         instret <= instret_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      instr_nxt   = instr;
      trap_nxt    = trap;
      instret_nxt = instret;
      case (state)
         BOOT: state_nxt = FETCH;
         FETCH: begin
            if (imem_ack) begin
               instr_nxt = imem_rdata;
               state_nxt = EXEC;
            end
         end
         EXEC: begin
            // a misaligned taken target leaves pc and instret untouched
            if (!stall) begin
               if (taken && (target[1:0] != 2'b00)) begin
                  trap_nxt  = 1'b1;
                  state_nxt = TRAP;
               end else begin
                  pc_nxt      = target;
                  instret_nxt = instret + 64'd1;
                  state_nxt   = FETCH;
               end
            end
         end
         TRAP: state_nxt = TRAP;
         default: state_nxt = BOOT;
      endcase
   end

endmodule

// File: tb/tb_pc_control.sv
// tb/tb_pc_control.sv - randomized and directed check of pc_control against a reference model
module tb_pc_control;

   localparam logic [63:0] RPC = 64'h1000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        branch = 1'b0;
   logic        jump = 1'b0;
   logic        alu_zero = 1'b0;
   logic [63:0] imm = 64'h0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic [31:0] instr;
   logic        instr_valid;
   logic [63:0] pc;
   logic [63:0] pc_plus4;
   logic        taken;
   logic        trap;
   logic [63:0] instret;

   pc_control #(.RESET_PC(RPC)) dut (
      .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr(instr),
      .instr_valid(instr_valid), .stall(stall), .branch(branch), .jump(jump),
      .alu_zero(alu_zero), .imm(imm), .pc(pc), .pc_plus4(pc_plus4),
      .taken(taken), .trap(trap), .instret(instret)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // reference model: phase 0 boot, 1 fetch, 2 exec, 3 trap
   int          m_phase = 0;
   logic [63:0] m_pc = RPC;
   logic [31:0] m_instr = 32'h0;
   logic        m_trap = 1'b0;
   logic [63:0] m_instret = 64'h0;
   bit          chk_en = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cycle();
      logic        m_taken;
      logic [63:0] tgt;
      @(negedge clk);
      #1;
      m_taken = (m_phase == 2) && (jump || (branch && alu_zero));
      if (chk_en) begin
         check("imem_req", 64'(imem_req), 64'(m_phase == 1));
         check("imem_addr", imem_addr, m_pc);
         check("instr_valid", 64'(instr_valid), 64'(m_phase == 2));
         check("taken", 64'(taken), 64'(m_taken));
         check("pc_plus4", pc_plus4, m_pc + 64'd4);
         check("pc", pc, m_pc);
         check("instr", 64'(instr), 64'(m_instr));
         check("trap", 64'(trap), 64'(m_trap));
         check("instret", instret, m_instret);
      end
      @(posedge clk);
      if (!reset_n) begin
         m_phase = 0; m_pc = RPC; m_instr = 32'h0; m_trap = 1'b0; m_instret = 64'h0;
         chk_en = 1'b1;
      end else if (m_phase == 0) begin
         m_phase = 1;
      end else if (m_phase == 1) begin
         if (imem_ack) begin
            m_instr = imem_rdata;
            m_phase = 2;
         end
      end else if (m_phase == 2 && !stall) begin
         tgt = m_taken ? m_pc + imm : m_pc + 64'd4;
         if (m_taken && (tgt % 4 != 0)) begin
            m_trap = 1'b1;
            m_phase = 3;
         end else begin
            m_pc = tgt;
            m_instret = m_instret + 64'd1;
            m_phase = 1;
         end
      end
      #1;
   endtask

   task automatic idle_ctrl();
      stall = 1'b0; branch = 1'b0; jump = 1'b0; alu_zero = 1'b0; imm = 64'h0;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      cycle();
      reset_n = 1'b1;
   endtask

   logic [63:0] saved;
   longint      off;

   initial begin
      // sequential fetch after reset
      idle_ctrl();
      imem_ack = 1'b1;
      imem_rdata = 32'h0000_0013;
      do_reset();
      check("reset_pc", pc, RPC);
      check("reset_req", 64'(imem_req), 64'd0);
      cycle();
      check("first_req", 64'(imem_req), 64'd1);
      for (int i = 0; i < 6; i++) cycle();
      check("seq_instret", instret, 64'd3);
      check("seq_addr", imem_addr, 64'h100C);

      // taken branch backwards, then not-taken
      do_reset();
      cycle(); cycle();
      branch = 1'b1; alu_zero = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFF0;
      cycle();
      check("br_taken_addr", imem_addr, 64'hFF0);
      idle_ctrl();
      do_reset();
      cycle(); cycle();
      branch = 1'b1; imm = 64'hFFFF_FFFF_FFFF_FFF0;
      cycle();
      check("br_nt_addr", imem_addr, 64'h1004);
      idle_ctrl();

      // jal to 0x2040 from 0x2000
      do_reset();
      cycle(); cycle();
      jump = 1'b1; imm = 64'h1000;
      cycle();
      idle_ctrl();
      cycle();
      jump = 1'b1; branch = 1'b1; imm = 64'h40;
      check("jal_link", pc_plus4, 64'h2004);
      cycle();
      check("jal_addr", imem_addr, 64'h2040);
      idle_ctrl();

      // ack wait 3 cycles, stall 2 cycles: 7 cycles, one retirement
      do_reset();
      cycle();
      saved = instret;
      imem_ack = 1'b0;
      imem_rdata = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) cycle();
      imem_ack = 1'b1;
      cycle();
      imem_ack = 1'b0;
      stall = 1'b1;
      cycle(); cycle();
      check("stall_instr", 64'(instr), 64'hDEAD_BEEF);
      stall = 1'b0;
      cycle();
      check("stall_instret", instret, saved + 64'd1);
      check("stall_refetch", 64'(imem_req), 64'd1);
      imem_ack = 1'b1;

      // misaligned taken target traps until reset
      do_reset();
      cycle(); cycle();
      branch = 1'b1; alu_zero = 1'b1; imm = 64'h6;
      cycle();
      idle_ctrl();
      for (int i = 0; i < 4; i++) cycle();
      check("trap_pc", pc, 64'h1000);
      check("trap_flag", 64'(trap), 64'd1);

      // wrap-around from the top of the address space
      do_reset();
      cycle(); cycle();
      jump = 1'b1; imm = 64'hFFFF_FFFF_FFFF_EFFC;
      cycle();
      idle_ctrl();
      cycle(); cycle();
      check("wrap_pc", pc, 64'h0);
      check("wrap_trap", 64'(trap), 64'd0);

      // reset while stalled in EXEC
      cycle();
      stall = 1'b1;
      cycle(); cycle();
      do_reset();
      check("mid_reset_pc", pc, RPC);
      check("mid_reset_valid", 64'(instr_valid), 64'd0);
      check("mid_reset_instret", instret, 64'd0);
      stall = 1'b0;
      cycle(); cycle();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         reset_n    = ($urandom_range(0, 39) != 0);
         imem_ack   = ($urandom_range(0, 1) == 1);
         imem_rdata = $urandom;
         stall      = ($urandom_range(0, 3) == 0);
         branch     = ($urandom_range(0, 1) == 1);
         jump       = ($urandom_range(0, 3) == 0);
         alu_zero   = ($urandom_range(0, 1) == 1);
         case ($urandom_range(0, 15))
            0: imm = {$urandom, $urandom};
            1: imm = 64'hFFFF_FFFF_FFFF_FFFC - m_pc;
            default: begin
               off = longint'($urandom_range(0, 255)) - 128;
               imm = 64'(off * 4);
            end
         endcase
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter and instruction-sequencing block for the 64-bit RISC-V core, sitting directly downstream of the 64-bit ALU. It consumes the ALU's ZERO condition flag (branch-condition-true for beq/blt/bge/jal) together with decode control and the immediate. It computes and registers the next PC and drives a request/acknowledge fetch handshake to instruction memory. It also presents the fetched instruction to decode, supplies pc+4 for link writeback, flags misaligned control transfers, and counts retired instructions.

## Interface
- RESET_PC, 64'h0, PC value loaded on reset; must be 4-byte aligned.
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-low reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  64  fetch address; equals pc.
- imem_ack  input  1  memory has valid data on imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  latched instruction for decode.
- instr_valid  output  1  instr is valid; the datapath is executing it.
- stall  input  1  hold current instruction in EXEC; no commit.
- branch  input  1  current instruction is a conditional branch.
- jump  input  1  current instruction is jal.
- alu_zero  input  1  ALU ZERO output (condition true).
- imm  input  64  sign-extended byte offset from the immediate generator, already scaled.
- pc  output  64  address of the current instruction.
- pc_plus4  output  64  pc + 4 (mod 2^64), used as the link value.
- taken  output  1  combinational: EXEC and (jump or (branch and alu_zero)).
- trap  output  1  misaligned target detected; sticky until reset.
- instret  output  64  count of committed instructions.

## Operation
- FSM states: BOOT, FETCH, EXEC, TRAP.
- BOOT: imem_req=0, instr_valid=0. Goes to FETCH on the next cycle unconditionally.
- FETCH: imem_req=1, imem_addr=pc. Stays in FETCH while imem_ack=0. On imem_ack=1: instr<=imem_rdata, next state EXEC.
- EXEC: instr_valid=1, imem_req=0. While stall=1, holds the state, pc and instr. When stall=0, commits:
  - target = pc + imm if taken, else pc + 4. All adds are 64-bit modulo 2^64; wrap-around is legal.
  - jump has priority over branch. Both are evaluated regardless, and both select pc+imm.
  - If taken and target[1:0] != 0: pc is unchanged, instret is unchanged, trap<=1, next state TRAP.
  - Otherwise: pc<=target, instret<=instret+1 (wraps), next state FETCH.
- TRAP: imem_req=0, instr_valid=0, trap=1. Left only by reset.
- imem_ack outside FETCH is ignored. imem_rdata is captured only on the FETCH acknowledgement.
- stall outside EXEC has no effect.
- branch, jump, alu_zero and imm are sampled only at the EXEC commit edge.
- jalr is not handled by this block.

## Timing
- Reset (reset_n=0 at a rising edge) forces: state=BOOT, pc=RESET_PC, instr=32'h0, trap=0, instret=0. Resulting outputs: imem_req=0, instr_valid=0, taken=0.
- Reset asserted mid-operation (FETCH awaiting ack, EXEC under stall, or TRAP) aborts immediately at that edge. The pending instruction is not committed and not counted.
- First imem_req rises one cycle after the first edge with reset_n=1.
- imem_req, imem_addr, instr_valid and trap decode from registered state only. taken and pc_plus4 are combinational from pc and inputs.
- Minimum throughput: 2 cycles per instruction (FETCH with same-cycle ack, then EXEC with stall=0). Each ack-wait cycle and each stall cycle adds one cycle.
- pc updates on the same edge that leaves EXEC. imem_addr shows the new PC in the next FETCH cycle.

## Test plan
- Reset release with RESET_PC=0x1000, imem_ack tied 1, all control 0 -> BOOT 1 cycle; fetches at 0x1000, 0x1004, 0x1008, one every 2 cycles; instret increments 1, 2, 3.
- Taken branch: pc=0x1000, branch=1, alu_zero=1, imm=-16 -> next imem_addr=0xFF0, taken=1 during EXEC. Same case with alu_zero=0 -> 0x1004.
- jal: pc=0x2000, jump=1, branch=1, alu_zero=0, imm=0x40 -> pc_plus4=0x2004 in EXEC; next fetch 0x2040.
- Handshake and stall: imem_ack low for 3 FETCH cycles, then high; stall=1 for 2 EXEC cycles -> instruction takes 7 cycles total; instr holds; instret increments once.
- Misalignment and wrap: taken branch from 0x1000 with imm=0x6 -> trap=1, pc stays 0x1000, imem_req stays 0 until reset. Sequential commit at pc=0xFFFF_FFFF_FFFF_FFFC -> next pc=0x0, no trap.
- Reset mid-EXEC under stall -> at the next edge: pc=RESET_PC, instr_valid=0, instret=0, trap=0; fetch resumes after BOOT.
